// File: rtl/rst_seq_pkg.sv
// Shared types and limits for the reset sequencer.
// The state names carry an ST_ prefix so they do not clash with the HOLD/GAP parameters.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_REL  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    localparam int NCH_MAX = 16;
    localparam int CW_MIN  = 1;

    // The channel index register is never narrower than one bit, even when NCH is 1.
    function automatic int idxw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rst_seq_en_cnt.sv
// EN-qualified interval counter. It clears itself on its terminal count, and clr wins over counting.
module en_cnt #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] tc_val,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc  = en & (cnt_q == tc_val);
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tc) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer. After reset it holds NCH active-low resets, then releases them in
// ascending order. The hold and gap intervals count only edges where EN is high.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int CW   = 8,
    parameter int HOLD = 4,
    parameter int GAP  = 2
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           EN,
    input  logic           SRST_REQ,
    output logic [NCH-1:0] IR_N,
    output logic           DONE
);

    localparam int IDXW   = idxw(NCH);
    localparam bit SINGLE = (NCH == 1);

    // Reject out-of-range parameters at elaboration time.
    // The check (X >> CW) != 0 is true exactly when X does not fit in CW bits.
    generate
        if (NCH < 1 || NCH > NCH_MAX) begin : g_bad_nch
            $error("rst_seq: NCH out of range");
        end
        if (CW < CW_MIN) begin : g_bad_cw
            $error("rst_seq: CW out of range");
        end
        if (HOLD < 1 || (HOLD >> CW) != 0) begin : g_bad_hold
            $error("rst_seq: HOLD out of range");
        end
        if (GAP < 1 || (GAP >> CW) != 0) begin : g_bad_gap
            $error("rst_seq: GAP out of range");
        end
    endgenerate

    state_e          state_q;
    state_e          state_d;
    logic [IDXW-1:0] idx_q;
    logic [IDXW-1:0] idx_d;
    logic [NCH-1:0]  ir_n_q;
    logic [NCH-1:0]  ir_n_d;
    logic            done_q;
    logic            done_d;

    logic [NCH-1:0]  rel_stb;
    logic [CW-1:0]   tc_val;
    logic [CW-1:0]   cnt_unused;
    logic            cnt_en;
    logic            tc;
    logic            last_ch;

    // The counter is frozen in FIN, so EN has no effect after the last release.
    assign cnt_en  = EN & (state_q != ST_FIN);
    assign tc_val  = (state_q == ST_HOLD) ? CW'(HOLD - 1) : CW'(GAP - 1);
    assign last_ch = (state_q == ST_REL) && (idx_q == IDXW'(NCH - 1));

    en_cnt #(
        .CW(CW)
    ) u_cnt (
        .clk    (CLK),
        .srst   (RST),
        .clr    (SRST_REQ),
        .en     (cnt_en),
        .tc_val (tc_val),
        .cnt    (cnt_unused),
        .tc     (tc)
    );

    // One release strobe per channel. Channel 0 leaves HOLD; the others follow idx in REL.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_rel
            if (gi == 0) begin : g_first
                assign rel_stb[gi] = tc & (state_q == ST_HOLD);
            end else begin : g_next
                assign rel_stb[gi] = tc & (state_q == ST_REL) & (idx_q == IDXW'(gi));
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (SRST_REQ) begin
            state_d = ST_HOLD;
        end else begin
            case (state_q)
                ST_HOLD: if (tc) state_d = SINGLE ? ST_FIN : ST_REL;
                ST_REL:  if (tc && last_ch) state_d = ST_FIN;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        ir_n_d = ir_n_q | rel_stb;
        idx_d  = idx_q;
        done_d = done_q;
        if (rel_stb != '0) begin
            idx_d = idx_q + IDXW'(1);
        end
        if (tc && ((state_q == ST_REL && last_ch) || (state_q == ST_HOLD && SINGLE))) begin
            done_d = 1'b1;
        end
        // A soft reset wins over any release that falls due on the same edge.
        if (SRST_REQ) begin
            ir_n_d = '0;
            idx_d  = '0;
            done_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ir_n_q <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            ir_n_q <= ir_n_d;
            idx_q  <= idx_d;
            done_q <= done_d;
        end
    end

    assign IR_N = ir_n_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq. It runs a 4-channel and a single-channel instance in parallel against
// a model that counts qualified edges.
module tb_rst_seq;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b1;
    logic       SRST_REQ = 1'b0;
    logic [3:0] ir_n4;
    logic       done4;
    logic [0:0] ir_n1;
    logic       done1;

    int n_assert = 0;
    int n_fail   = 0;

    int  e_cnt = 0;
    bit  model_ok = 1'b0;

    always #5 CLK = ~CLK;

    rst_seq #(.NCH(4), .CW(8), .HOLD(4), .GAP(2)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .SRST_REQ(SRST_REQ), .IR_N(ir_n4), .DONE(done4)
    );

    rst_seq #(.NCH(1), .CW(8), .HOLD(1), .GAP(1)) dut1 (
        .CLK(CLK), .RST(RST), .EN(EN), .SRST_REQ(SRST_REQ), .IR_N(ir_n1), .DONE(done1)
    );

    // Released channels after e qualified edges: first at HOLD, then one every GAP.
    function automatic int n_rel(input int e, input int nch, input int hold, input int gap);
        int r;
        if (e < hold) return 0;
        r = 1 + (e - hold) / gap;
        return (r > nch) ? nch : r;
    endfunction

    function automatic logic [15:0] mask_of(input int r);
        logic [16:0] one;
        one = 17'd1;
        return 16'((one << r) - 17'd1);
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge CLK);
        #3;
    endtask

    // Qualified-edge count since the last RST or soft reset. FIN simply saturates the release count.
    always @(posedge CLK) begin
        if (RST || SRST_REQ) begin
            e_cnt    = 0;
            model_ok = 1'b1;
        end else if (EN && e_cnt < 1000) begin
            e_cnt++;
        end
    end

    always @(negedge CLK) begin
        if (model_ok) begin
            chk("cyc_irn4", {12'd0, ir_n4}, mask_of(n_rel(e_cnt, 4, 4, 2)));
            chk("cyc_done4", {15'd0, done4}, {15'd0, n_rel(e_cnt, 4, 4, 2) == 4});
            chk("cyc_irn1", {15'd0, ir_n1}, mask_of(n_rel(e_cnt, 1, 1, 1)));
            chk("cyc_done1", {15'd0, done1}, {15'd0, n_rel(e_cnt, 1, 1, 1) == 1});
        end
    end

    initial begin
        // Reset state
        edges(2);
        chk("rst_irn4", {12'd0, ir_n4}, 16'h0000);
        chk("rst_done4", {15'd0, done4}, 16'h0000);
        chk("rst_irn1", {15'd0, ir_n1}, 16'h0000);

        // Power-up with EN held high
        RST = 1'b0;
        edges(1);
        chk("deg_irn1_e1", {15'd0, ir_n1}, 16'h0001);
        chk("deg_done1_e1", {15'd0, done1}, 16'h0001);
        edges(2);
        chk("pwr_e3", {12'd0, ir_n4}, 16'h0000);
        edges(1);
        chk("pwr_e4", {12'd0, ir_n4}, 16'h0001);
        edges(2);
        chk("pwr_e6", {12'd0, ir_n4}, 16'h0003);
        edges(2);
        chk("pwr_e8", {12'd0, ir_n4}, 16'h0007);
        chk("pwr_done_e8", {15'd0, done4}, 16'h0000);
        edges(2);
        chk("pwr_e10", {12'd0, ir_n4}, 16'h000f);
        chk("pwr_done_e10", {15'd0, done4}, 16'h0001);

        // Soft reset pulse on edge 7
        RST = 1'b1;
        edges(1);
        RST = 1'b0;
        edges(6);
        chk("srst_e6", {12'd0, ir_n4}, 16'h0003);
        SRST_REQ = 1'b1;
        edges(1);
        SRST_REQ = 1'b0;
        chk("srst_e7", {12'd0, ir_n4}, 16'h0000);
        edges(3);
        chk("srst_e10", {12'd0, ir_n4}, 16'h0000);
        edges(1);
        chk("srst_e11", {12'd0, ir_n4}, 16'h0001);
        edges(5);
        chk("srst_done_e16", {15'd0, done4}, 16'h0000);
        edges(1);
        chk("srst_done_e17", {15'd0, done4}, 16'h0001);

        // Soft reset colliding with the final release on edge 10
        RST = 1'b1;
        edges(1);
        RST = 1'b0;
        edges(9);
        chk("coll_e9", {12'd0, ir_n4}, 16'h0007);
        SRST_REQ = 1'b1;
        edges(1);
        chk("coll_e10", {12'd0, ir_n4}, 16'h0000);
        chk("coll_done_e10", {15'd0, done4}, 16'h0000);
        edges(4);
        chk("coll_hold", {12'd0, ir_n4}, 16'h0000);
        SRST_REQ = 1'b0;

        // EN high on even edges only
        RST = 1'b1;
        edges(1);
        RST = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            EN = (e % 2 == 0);
            edges(1);
            if (e == 7) chk("en_e7", {12'd0, ir_n4}, 16'h0000);
            if (e == 8) chk("en_e8", {12'd0, ir_n4}, 16'h0001);
            if (e == 19) chk("en_done_e19", {15'd0, done4}, 16'h0000);
            if (e == 20) chk("en_done_e20", {15'd0, done4}, 16'h0001);
        end
        EN = 1'b1;

        // RST while in FIN, then RST and soft reset together
        edges(2);
        RST = 1'b1;
        #1;
        chk("fin_before_rst", {12'd0, ir_n4}, 16'h000f);
        edges(1);
        chk("fin_rst", {12'd0, ir_n4}, 16'h0000);
        SRST_REQ = 1'b1;
        edges(1);
        chk("rst_srst", {15'd0, done4}, 16'h0000);
        RST = 1'b0;
        SRST_REQ = 1'b0;
        edges(3);
        chk("re_e3", {12'd0, ir_n4}, 16'h0000);
        edges(1);
        chk("re_e4", {12'd0, ir_n4}, 16'h0001);
        edges(6);
        chk("re_e10", {12'd0, ir_n4}, 16'h000f);

        // Random EN, soft reset and reset, checked by the per-cycle model compare
        for (int i = 0; i < 2000; i++) begin
            EN       = ($urandom_range(99) < 70);
            SRST_REQ = ($urandom_range(99) < 3);
            RST      = ($urandom_range(99) < 1);
            edges(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
